// File: rtl/cpu_pkg.sv
// Shared register-map definitions for the CPU datapath.
// Both the register file and the microsequencer decode register indices
// through these helpers, so they always agree on where LR, SP and PC sit.
//  - DEFAULT_DATA_WIDTH : default register/bus width
//  - REG_LR/REG_SP/REG_PC(num_gp) : special-register indices after the GP block
//  - sel_width_ok(num_gp, sel_width) : elaboration check that the index fits
package cpu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    function automatic int REG_LR(input int num_gp);
        return num_gp;
    endfunction

    function automatic int REG_SP(input int num_gp);
        return num_gp + 1;
    endfunction

    function automatic int REG_PC(input int num_gp);
        return num_gp + 2;
    endfunction

    // True when every register (GP block + LR + SP + PC) has an index.
    function automatic bit sel_width_ok(input int num_gp, input int sel_width);
        return (num_gp + 3) <= (1 << sel_width);
    endfunction

endpackage

// File: rtl/regfile_bus_if.sv
// Bus bundle between the microsequencer (master) and the register file (slave).
// Carries read/write selects and enables, the data bus, PC/SP step requests,
// and the register file's status outputs (PC, SP, sticky fault flags).
interface regfile_bus_if #(
    parameter int DATA_WIDTH = cpu_pkg::DEFAULT_DATA_WIDTH,
    parameter int SEL_WIDTH  = 3
);
    logic                  oe_en;
    logic [SEL_WIDTH-1:0]  oe_sel;
    logic                  load_en;
    logic [SEL_WIDTH-1:0]  load_sel;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  pc_inc;
    logic                  sp_inc;
    logic                  sp_dec;
    logic [DATA_WIDTH-1:0] pc_out;
    logic [DATA_WIDTH-1:0] sp_out;
    logic                  sel_fault;
    logic                  sp_fault;

    modport master (
        output oe_en, oe_sel, load_en, load_sel, data_in, pc_inc, sp_inc, sp_dec,
        input  data_out, pc_out, sp_out, sel_fault, sp_fault
    );

    modport slave (
        input  oe_en, oe_sel, load_en, load_sel, data_in, pc_inc, sp_inc, sp_dec,
        output data_out, pc_out, sp_out, sel_fault, sp_fault
    );
endinterface

// File: rtl/step_reg.sv
// Single register with load / increment / decrement / hold.
// Load beats stepping; inc and dec together cancel to a hold.
// Ports:
//  clock, reset      rising-edge clock, synchronous active-low reset
//  load, load_value  parallel load request and value
//  inc, dec          step requests
//  value             current register contents
//  wrap              high in a cycle whose step crosses 0 <-> all-ones
module step_reg #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] value_next;
    logic             wrap_next;

    always_comb begin
        value_next = value_reg;
        wrap_next  = 1'b0;
        if (load) begin
            value_next = load_value;
        end else if (inc && !dec) begin
            value_next = value_reg + ONE;
            wrap_next  = &value_reg;
        end else if (dec && !inc) begin
            value_next = value_reg - ONE;
            wrap_next  = ~|value_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            value_reg <= RESET_VALUE;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;
    assign wrap  = wrap_next;
endmodule

// File: rtl/regfile_bus.sv
// CPU register file: NUM_GP general registers, LR, SP and PC behind one
// indexed bus port, with PC auto-increment, SP push/pop stepping and sticky
// fault flags.
// Ports:
//  clock  rising-edge clock
//  reset  synchronous, active-low
//  bus    slave side of regfile_bus_if (selects, enables, data, steps,
//         PC/SP outputs, sel_fault, sp_fault)
// Index map: 0..NUM_GP-1 GP, NUM_GP LR, NUM_GP+1 SP, NUM_GP+2 PC.
module regfile_bus #(
    parameter int                    DATA_WIDTH = cpu_pkg::DEFAULT_DATA_WIDTH,
    parameter int                    NUM_GP     = 5,
    parameter int                    SEL_WIDTH  = 3,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = '0
) (
    input logic           clock,
    input logic           reset,
    regfile_bus_if.slave  bus
);
    import cpu_pkg::*;

    localparam int IDX_LR   = REG_LR(NUM_GP);
    localparam int IDX_SP   = REG_SP(NUM_GP);
    localparam int IDX_PC   = REG_PC(NUM_GP);
    localparam int NUM_REGS = IDX_PC + 1;

    if (!sel_width_ok(NUM_GP, SEL_WIDTH)) begin : g_sel_width_check
        $error("regfile_bus: SEL_WIDTH too small for NUM_GP+3 registers");
    end

    logic                  oe_valid;
    logic                  load_valid;
    logic                  pc_load;
    logic                  sp_load;
    logic [DATA_WIDTH-1:0] pc_value;
    logic [DATA_WIDTH-1:0] sp_value;
    logic                  sp_wrap;
    logic                  pc_wrap_unused;
    logic [NUM_GP:0]       wr_hot;
    logic [DATA_WIDTH-1:0] gp_reg [NUM_GP+1];
    logic [DATA_WIDTH-1:0] view [NUM_REGS];
    logic [DATA_WIDTH-1:0] data_out_next;
    logic                  sel_fault_reg;
    logic                  sp_fault_reg;

    assign oe_valid   = int'(bus.oe_sel) < NUM_REGS;
    assign load_valid = int'(bus.load_sel) < NUM_REGS;
    assign pc_load    = bus.load_en && (int'(bus.load_sel) == IDX_PC);
    assign sp_load    = bus.load_en && (int'(bus.load_sel) == IDX_SP);

    // PC never decrements; its wrap is silent, so the flag is dropped.
    step_reg #(.WIDTH(DATA_WIDTH), .RESET_VALUE(PC_RESET)) u_pc (
        .clock      (clock),
        .reset      (reset),
        .load       (pc_load),
        .load_value (bus.data_in),
        .inc        (bus.pc_inc),
        .dec        (1'b0),
        .value      (pc_value),
        .wrap       (pc_wrap_unused)
    );

    step_reg #(.WIDTH(DATA_WIDTH), .RESET_VALUE(SP_RESET)) u_sp (
        .clock      (clock),
        .reset      (reset),
        .load       (sp_load),
        .load_value (bus.data_in),
        .inc        (bus.sp_inc),
        .dec        (bus.sp_dec),
        .value      (sp_value),
        .wrap       (sp_wrap)
    );

    // One-hot write decode for GP and LR; indices outside the array never match.
    for (genvar gi = 0; gi <= NUM_GP; gi++) begin : g_wr_decode
        assign wr_hot[gi] = bus.load_en && (int'(bus.load_sel) == gi);
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i <= NUM_GP; i++) begin
            if (!reset) begin
                gp_reg[i] <= '0;
            end else if (wr_hot[i]) begin
                gp_reg[i] <= bus.data_in;
            end
        end
    end

    // Flat view of every register in index order, feeding the read mux.
    for (genvar gi = 0; gi <= NUM_GP; gi++) begin : g_view
        assign view[gi] = gp_reg[gi];
    end
    assign view[IDX_SP] = sp_value;
    assign view[IDX_PC] = pc_value;

    always_comb begin
        data_out_next = '0;
        if (bus.oe_en && oe_valid) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(bus.oe_sel) == i) begin
                    data_out_next = view[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sel_fault_reg <= 1'b0;
            sp_fault_reg  <= 1'b0;
        end else begin
            if ((bus.oe_en && !oe_valid) || (bus.load_en && !load_valid)) begin
                sel_fault_reg <= 1'b1;
            end
            if (sp_wrap) begin
                sp_fault_reg <= 1'b1;
            end
        end
    end

    assign bus.data_out  = data_out_next;
    assign bus.pc_out    = pc_value;
    assign bus.sp_out    = sp_value;
    assign bus.sel_fault = sel_fault_reg;
    assign bus.sp_fault  = sp_fault_reg;
endmodule

// File: tb/tb_regfile_bus.sv
// Self-checking bench for regfile_bus. Two instances share one stimulus set:
// dut_a (NUM_GP=4, SEL_WIDTH=3, index 7 invalid) and dut_b (NUM_GP=8,
// SEL_WIDTH=4, indices 11..15 invalid). Only the selected instance sees
// enables/steps; the other idles. A behavioural model of the register map
// predicts every output.
module tb_regfile_bus;
    localparam logic [15:0] PC_RST = 16'h0010;
    localparam logic [15:0] SP_RST = 16'h0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cur = 0;

    logic        s_oe_en, s_load_en, s_pc_inc, s_sp_inc, s_sp_dec;
    logic [3:0]  s_oe_sel, s_load_sel;
    logic [15:0] s_data_in;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [15:0] m_regs [16];
    logic        m_self, m_spf;
    int          ng, sw;

    always #5 clk = ~clk;

    regfile_bus_if #(.DATA_WIDTH(16), .SEL_WIDTH(3)) bus_a ();
    regfile_bus_if #(.DATA_WIDTH(16), .SEL_WIDTH(4)) bus_b ();

    assign bus_a.oe_en    = (cur == 0) && s_oe_en;
    assign bus_a.oe_sel   = s_oe_sel[2:0];
    assign bus_a.load_en  = (cur == 0) && s_load_en;
    assign bus_a.load_sel = s_load_sel[2:0];
    assign bus_a.data_in  = s_data_in;
    assign bus_a.pc_inc   = (cur == 0) && s_pc_inc;
    assign bus_a.sp_inc   = (cur == 0) && s_sp_inc;
    assign bus_a.sp_dec   = (cur == 0) && s_sp_dec;

    assign bus_b.oe_en    = (cur == 1) && s_oe_en;
    assign bus_b.oe_sel   = s_oe_sel;
    assign bus_b.load_en  = (cur == 1) && s_load_en;
    assign bus_b.load_sel = s_load_sel;
    assign bus_b.data_in  = s_data_in;
    assign bus_b.pc_inc   = (cur == 1) && s_pc_inc;
    assign bus_b.sp_inc   = (cur == 1) && s_sp_inc;
    assign bus_b.sp_dec   = (cur == 1) && s_sp_dec;

    regfile_bus #(.DATA_WIDTH(16), .NUM_GP(4), .SEL_WIDTH(3),
                  .PC_RESET(PC_RST), .SP_RESET(SP_RST)) dut_a (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    regfile_bus #(.DATA_WIDTH(16), .NUM_GP(8), .SEL_WIDTH(4),
                  .PC_RESET(PC_RST), .SP_RESET(SP_RST)) dut_b (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_b)
    );

    logic [15:0] o_data, o_pc, o_sp;
    logic        o_self, o_spf;
    assign o_data = (cur == 0) ? bus_a.data_out  : bus_b.data_out;
    assign o_pc   = (cur == 0) ? bus_a.pc_out    : bus_b.pc_out;
    assign o_sp   = (cur == 0) ? bus_a.sp_out    : bus_b.sp_out;
    assign o_self = (cur == 0) ? bus_a.sel_fault : bus_b.sel_fault;
    assign o_spf  = (cur == 0) ? bus_a.sp_fault  : bus_b.sp_fault;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, cur, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read();
        if (s_oe_en && int'(s_oe_sel) < ng + 3) return m_regs[s_oe_sel];
        return 16'h0000;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        m_regs[ng + 1] = SP_RST;
        m_regs[ng + 2] = PC_RST;
        m_self = 1'b0;
        m_spf  = 1'b0;
    endtask

    // One clock edge of the register map, straight from the behavioural rules.
    task automatic m_edge();
        logic [15:0] pc, sp;
        bit          ld_ok;
        if (!rst_n) begin
            m_reset();
            return;
        end
        pc    = m_regs[ng + 2];
        sp    = m_regs[ng + 1];
        ld_ok = int'(s_load_sel) < ng + 3;
        if ((s_oe_en && int'(s_oe_sel) >= ng + 3) || (s_load_en && !ld_ok)) m_self = 1'b1;
        if (s_load_en && ld_ok) m_regs[s_load_sel] = s_data_in;
        if (!(s_load_en && int'(s_load_sel) == ng + 2) && s_pc_inc)
            m_regs[ng + 2] = pc + 16'd1;
        if (!(s_load_en && int'(s_load_sel) == ng + 1) && (s_sp_inc != s_sp_dec)) begin
            if (s_sp_inc) begin
                m_regs[ng + 1] = sp + 16'd1;
                if (sp == 16'hFFFF) m_spf = 1'b1;
            end else begin
                m_regs[ng + 1] = sp - 16'd1;
                if (sp == 16'h0000) m_spf = 1'b1;
            end
        end
    endtask

    task automatic idle();
        s_oe_en = 0; s_oe_sel = 0; s_load_en = 0; s_load_sel = 0;
        s_data_in = 0; s_pc_inc = 0; s_sp_inc = 0; s_sp_dec = 0;
    endtask

    // Check every output against the model, then take one edge.
    task automatic step(input string tag);
        #2;
        check({tag, ".data_out"},  o_data, m_read());
        check({tag, ".pc_out"},    o_pc,   m_regs[ng + 2]);
        check({tag, ".sp_out"},    o_sp,   m_regs[ng + 1]);
        check({tag, ".sel_fault"}, {15'd0, o_self}, {15'd0, m_self});
        check({tag, ".sp_fault"},  {15'd0, o_spf},  {15'd0, m_spf});
        @(posedge clk);
        m_edge();
        #1;
        $display("dut%0d %s: data_out=%h pc=%h sp=%h sel_fault=%0b sp_fault=%0b",
                 cur, tag, o_data, o_pc, o_sp, o_self, o_spf);
    endtask

    task automatic load(input int sel, input logic [15:0] val, input string tag);
        idle();
        s_load_en = 1; s_load_sel = 4'(sel); s_data_in = val;
        step(tag);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < (1 << sw); i++) begin
            idle();
            s_oe_en = 1; s_oe_sel = 4'(i);
            step(tag);
        end
    endtask

    task automatic run_suite();
        int lr, spi, pci, bad;
        lr = ng; spi = ng + 1; pci = ng + 2; bad = ng + 3;

        // reset mid-run with state and a fault present; reset beats a load and pc_inc
        load(0, 16'h1111, "pre_r0");
        load(lr, 16'h2222, "pre_lr");
        load(pci, 16'h1234, "pre_pc");
        load(spi, 16'h0040, "pre_sp");
        load(bad, 16'h3333, "pre_bad");
        idle(); s_oe_en = 1; s_oe_sel = 4'(pci); step("pre_hold");
        rst_n = 0; s_pc_inc = 1; s_load_en = 1; s_load_sel = 0; s_data_in = 16'hFFFF;
        step("reset");
        rst_n = 1;
        read_all("post_reset");

        // write latency: same-cycle read returns old value
        idle(); s_load_en = 1; s_load_sel = 2; s_data_in = 16'hBEEF;
        s_oe_en = 1; s_oe_sel = 2; step("r2_load");
        idle(); s_oe_en = 1; s_oe_sel = 2; step("r2_read");

        // PC wrap and load priority
        load(pci, 16'hFFFE, "pc_load");
        for (int i = 0; i < 3; i++) begin
            idle(); s_pc_inc = 1; step("pc_inc");
        end
        s_load_en = 1; s_load_sel = 4'(pci); s_data_in = 16'h0100; step("pc_inc_load");
        idle(); step("pc_after");

        // SP wrap, cancelling steps, load priority
        load(spi, 16'h0000, "sp_zero");
        idle(); s_sp_dec = 1; step("sp_dec_wrap");
        idle(); step("sp_fault_sticky");
        load(spi, 16'h0010, "sp_10");
        idle(); s_sp_inc = 1; s_sp_dec = 1; step("sp_both");
        s_load_en = 1; s_load_sel = 4'(spi); s_data_in = 16'h0200; s_sp_inc = 0; step("sp_load_dec");
        idle(); step("sp_after");

        // invalid index on load and on read
        load(bad, 16'hAAAA, "bad_load");
        idle(); s_oe_en = 1; s_oe_sel = 4'(bad); step("bad_read");

        // LR -> r0 bus move
        load(lr, 16'h5A5A, "lr_load");
        idle(); s_oe_en = 1; s_oe_sel = 4'(lr);
        s_load_en = 1; s_load_sel = 0; s_data_in = m_read(); step("move_lr_r0");
        idle(); s_oe_en = 1; s_oe_sel = 0; step("move_r0");
        read_all("directed_end");

        // randomized traffic, occasional reset
        for (int i = 0; i < 80; i++) begin
            rst_n      = ($urandom_range(0, 39) != 0);
            s_oe_en    = 1'($urandom_range(0, 1));
            s_oe_sel   = 4'($urandom_range(0, (1 << sw) - 1));
            s_load_en  = 1'($urandom_range(0, 1));
            s_load_sel = 4'($urandom_range(0, (1 << sw) - 1));
            s_data_in  = 16'($urandom);
            s_pc_inc   = 1'($urandom_range(0, 1));
            s_sp_inc   = 1'($urandom_range(0, 1));
            s_sp_dec   = 1'($urandom_range(0, 1));
            step("rand");
        end
        rst_n = 1;
        read_all("rand_end");
    endtask

    initial begin
        idle();
        rst_n = 0;
        ng = 4; sw = 3; cur = 0;
        repeat (2) @(posedge clk);
        m_reset();
        #1;
        rst_n = 1;
        run_suite();

        // switch to the wide instance; it has been held idle since reset
        cur = 1; ng = 8; sw = 4;
        m_reset();
        idle(); rst_n = 0; step("switch_reset");
        rst_n = 1;
        run_suite();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
